seven_seg_capture: RTL and testbench

//  Receive side of the multiplexed 7-segment bus: samples shared segment lines
//  (a..g, dp) and active-low digit anodes, demultiplexes them back into one

---
 rtl/seven_seg_capture.sv | 235 +++++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Receive side of a multiplexed 7-segment bus. Synchronizes the shared
//   segment lines and active-low anodes, waits for the bus to settle on a
//   single digit, latches that digit's pattern, and decodes it to hex.
// Ports
//   clock, reset_n            : clock and asynchronous active-low reset
//   seg_a..seg_g, seg_dp      : shared segment lines (async to clock)
//   an[NUM_DIGITS]            : active-low digit anodes
//   digit_hex[4*NUM_DIGITS]   : decoded value per digit
//   digit_dp / digit_known    : latched dp, pattern-is-a-hex-glyph flag
//   digit_valid               : digit captured within last TIMEOUT cycles
//   update_strobe/update_index: one-cycle capture pulse and its digit index
//   bus_error                 : one-cycle pulse on entry to >1 anode active
module seven_seg_capture #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SETTLE         = 4,
    parameter int unsigned TIMEOUT        = 1024,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      seg_a,
    input  logic                      seg_b,
    input  logic                      seg_c,
    input  logic                      seg_d,
    input  logic                      seg_e,
    input  logic                      seg_f,
    input  logic                      seg_g,
    input  logic                      seg_dp,
    input  logic [NUM_DIGITS-1:0]     an,
    output logic [4*NUM_DIGITS-1:0]   digit_hex,
    output logic [NUM_DIGITS-1:0]     digit_dp,
    output logic [NUM_DIGITS-1:0]     digit_known,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      update_strobe,
    output logic [2:0]                update_index,
    output logic                      bus_error
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam int unsigned HEX_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    // Raw bus level meaning "all segments off"
    localparam logic [7:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_MULTI   = 3'd4;

    // Decode an active-high {g..a} pattern to {known, hex}
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    logic [7:0]            seg_raw;
    logic [7:0]            seg_s1_q, seg_s2_q, seg_prev_q;
    logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q, an_prev_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            state_q, state_d;
    logic [NUM_DIGITS-1:0] an_cur_q, an_cur_d;

    logic [7:0]            seg_n;
    logic [NUM_DIGITS-1:0] low;
    logic                  none_low, single_low, changed, stable_done, capture;
    logic [2:0]            idx;
    logic [4:0]            dec;

    logic [HEX_W-1:0]      hex_q, hex_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d, known_q, known_d, valid_q, valid_d;
    logic [TMO_W-1:0]      tmo_q [NUM_DIGITS];
    logic [TMO_W-1:0]      tmo_d [NUM_DIGITS];
    logic                  strobe_q, berr_q;
    logic [2:0]            index_q;

    assign seg_raw = {seg_dp, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};

    // Normalized active-high {dp, g..a} from the synchronized bus
    assign seg_n = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
    assign dec   = decode(seg_n[6:0]);

    // Anode classification
    assign low        = ~an_s2_q;
    assign none_low   = (low == '0);
    assign single_low = !none_low && ((low & (low - NUM_DIGITS'(1))) == '0);

    always_comb begin
        idx = 3'd0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (low[i]) idx = 3'(i);
        end
    end

    // Stability counter over the whole synchronized bus
    assign changed     = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);
    assign cnt_d       = changed ? '0 : ((cnt_q == SETTLE_C) ? cnt_q : cnt_q + CNT_W'(1));
    assign stable_done = (cnt_d == SETTLE_C);

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        an_cur_d = an_cur_q;
        case (state_q)
            S_IDLE: begin
                if (single_low) begin
                    state_d  = S_SETTLE;
                    an_cur_d = an_s2_q;
                end else if (!none_low) begin
                    state_d = S_MULTI;
                end
            end
            S_SETTLE, S_HOLD: begin
                if (an_s2_q != an_cur_q) begin
                    if (none_low) begin
                        state_d = S_IDLE;
                    end else if (single_low) begin
                        state_d  = S_SETTLE;
                        an_cur_d = an_s2_q;
                    end else begin
                        state_d = S_MULTI;
                    end
                end else if (state_q == S_SETTLE && stable_done) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_HOLD;
            S_MULTI: begin
                if (none_low) begin
                    state_d = S_IDLE;
                end else if (single_low) begin
                    state_d  = S_SETTLE;
                    an_cur_d = an_s2_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture is registered on the edge that enters CAPTURE
    assign capture = (state_d == S_CAPTURE);

    // Per-digit latch and timeout; a capture overrides a simultaneous expiry
    always_comb begin
        hex_d   = hex_q;
        dp_d    = dp_q;
        known_d = known_q;
        valid_d = valid_q;
        tmo_d   = tmo_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (capture && idx == 3'(i)) begin
                hex_d[4*i +: 4] = dec[3:0];
                known_d[i]      = dec[4];
                dp_d[i]         = seg_n[7];
                tmo_d[i]        = TMO_LOAD;
                valid_d[i]      = 1'b1;
            end else begin
                tmo_d[i]   = (tmo_q[i] != '0) ? tmo_q[i] - TMO_W'(1) : '0;
                valid_d[i] = (tmo_d[i] != '0);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_s1_q   <= SEG_OFF;
            seg_s2_q   <= SEG_OFF;
            seg_prev_q <= SEG_OFF;
            an_s1_q    <= '1;
            an_s2_q    <= '1;
            an_prev_q  <= '1;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
            an_cur_q   <= '1;
            hex_q      <= '0;
            dp_q       <= '0;
            known_q    <= '0;
            valid_q    <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) tmo_q[i] <= '0;
            strobe_q   <= 1'b0;
            index_q    <= 3'd0;
            berr_q     <= 1'b0;
        end else begin
            seg_s1_q   <= seg_raw;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            an_s1_q    <= an;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            an_cur_q   <= an_cur_d;
            hex_q      <= hex_d;
            dp_q       <= dp_d;
            known_q    <= known_d;
            valid_q    <= valid_d;
            tmo_q      <= tmo_d;
            strobe_q   <= capture;
            index_q    <= capture ? idx : 3'd0;
            berr_q     <= (state_d == S_MULTI) && (state_q != S_MULTI);
        end
    end

    assign digit_hex     = hex_q;
    assign digit_dp      = dp_q;
    assign digit_known   = known_q;
    assign digit_valid   = valid_q;
    assign update_strobe = strobe_q;
    assign update_index  = index_q;
    assign bus_error     = berr_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (NUM_DIGITS=4, SETTLE=4, TIMEOUT=1024,
// active-low segments). Inputs change 1ns after a rising edge; outputs are
// sampled 1ns after each rising edge.
module tb_seven_seg_capture;

    logic       clock;
    logic       reset_n;
    logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp;
    logic [3:0] an;
    logic [15:0] digit_hex;
    logic [3:0] digit_dp, digit_known, digit_valid;
    logic       update_strobe;
    logic [2:0] update_index;
    logic       bus_error;

    int vectors;
    int miscompares;
    int tick_n;
    int strobe_cnt;
    int first_strobe;
    int berr_cnt;
    logic [2:0] last_idx;

    seven_seg_capture #(
        .NUM_DIGITS(4), .SETTLE(4), .TIMEOUT(1024), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
        .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g), .seg_dp(seg_dp),
        .an(an),
        .digit_hex(digit_hex), .digit_dp(digit_dp), .digit_known(digit_known),
        .digit_valid(digit_valid), .update_strobe(update_strobe),
        .update_index(update_index), .bus_error(bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the bus with an active-high pattern; lines are active-low
    task automatic set_bus(input logic [3:0] a, input logic [6:0] p, input logic d);
        an = a;
        {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = ~p;
        seg_dp = ~d;
    endtask

    task automatic clear_mon();
        tick_n       = 0;
        strobe_cnt   = 0;
        first_strobe = 0;
        berr_cnt     = 0;
        last_idx     = 3'd0;
    endtask

    // Advance n cycles, recording strobes and bus errors
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
            tick_n++;
            if (update_strobe === 1'b1) begin
                strobe_cnt++;
                if (first_strobe == 0) first_strobe = tick_n;
                last_idx = update_index;
            end
            if (bus_error === 1'b1) berr_cnt++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hex"},   32'(digit_hex),     32'h0);
        check({tag, "_dp"},    32'(digit_dp),      32'h0);
        check({tag, "_known"}, 32'(digit_known),   32'h0);
        check({tag, "_valid"}, 32'(digit_valid),   32'h0);
        check({tag, "_strb"},  32'(update_strobe), 32'h0);
        check({tag, "_idx"},   32'(update_index),  32'h0);
        check({tag, "_berr"},  32'(bus_error),     32'h0);
    endtask

    logic [3:0] scan_an  [4];
    logic [6:0] scan_pat [4];
    logic       scan_dp  [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_mon();
        scan_an[0] = 4'b1110; scan_pat[0] = 7'h71; scan_dp[0] = 1'b0; // F
        scan_an[1] = 4'b1101; scan_pat[1] = 7'h5B; scan_dp[1] = 1'b0; // 2
        scan_an[2] = 4'b1011; scan_pat[2] = 7'h77; scan_dp[2] = 1'b1; // A with dp
        scan_an[3] = 4'b0111; scan_pat[3] = 7'h06; scan_dp[3] = 1'b0; // 1

        reset_n = 1'b0;
        set_bus(4'b1111, 7'h00, 1'b0);
        run(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        run(3);
        check_all_zero("post_reset");

        // Single digit 3 on anode 0: strobe 2+SETTLE+1 = 7 cycles later
        clear_mon();
        set_bus(4'b1110, 7'h4F, 1'b0);
        run(20);
        check("t1_first_strobe", 32'(first_strobe), 32'd7);
        check("t1_strobe_cnt",   32'(strobe_cnt),   32'd1);
        check("t1_index",        32'(last_idx),     32'd0);
        check("t1_hex0",         32'(digit_hex[3:0]), 32'h3);
        check("t1_known0",       32'(digit_known[0]), 32'h1);
        check("t1_valid0",       32'(digit_valid[0]), 32'h1);

        // Round-robin scan, two passes, one strobe per dwell
        set_bus(4'b1111, 7'h00, 1'b0);
        run(6);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                clear_mon();
                set_bus(scan_an[i], scan_pat[i], scan_dp[i]);
                run(16);
                check($sformatf("t2_cnt_r%0d_d%0d", r, i), 32'(strobe_cnt), 32'd1);
                check($sformatf("t2_idx_r%0d_d%0d", r, i), 32'(last_idx),   32'(i));
            end
        end
        check("t2_hex",   32'(digit_hex),   32'h1A2F);
        check("t2_known", 32'(digit_known), 32'hF);
        check("t2_dp",    32'(digit_dp),    32'h4);
        check("t2_valid", 32'(digit_valid), 32'hF);

        // Two anodes low: one bus_error, nothing captured
        clear_mon();
        set_bus(4'b1100, 7'h7F, 1'b1);
        run(10);
        check("t3_berr_cnt",  32'(berr_cnt),   32'd1);
        check("t3_strobe",    32'(strobe_cnt), 32'd0);
        check("t3_hex",       32'(digit_hex),  32'h1A2F);
        check("t3_dp",        32'(digit_dp),   32'h4);
        set_bus(4'b1111, 7'h00, 1'b0);
        run(6);

        // Short glitch on anode 1 never settles
        clear_mon();
        set_bus(4'b1101, 7'h7F, 1'b0);
        run(3);
        set_bus(4'b1111, 7'h00, 1'b0);
        run(15);
        check("t4_strobe", 32'(strobe_cnt), 32'd0);
        check("t4_hex",    32'(digit_hex),  32'h1A2F);

        // Capture 5 on digit 1, then let it time out (valid drops 1030 cycles in)
        clear_mon();
        set_bus(4'b1101, 7'h6D, 1'b0);
        run(12);
        check("t5_strobe", 32'(strobe_cnt), 32'd1);
        check("t5_index",  32'(last_idx),   32'd1);
        check("t5_hex",    32'(digit_hex),  32'h1A5F);
        set_bus(4'b1111, 7'h00, 1'b0);
        run(988);
        check("t5_valid1_alive",   32'(digit_valid[1]), 32'h1);
        run(40);
        check("t5_valid1_expired", 32'(digit_valid[1]), 32'h0);
        check("t5_valid_all",      32'(digit_valid),    32'h0);
        check("t5_hex_kept",       32'(digit_hex),      32'h1A5F);
        check("t5_known_kept",     32'(digit_known),    32'hF);

        // Blank pattern on digit 2
        clear_mon();
        set_bus(4'b1011, 7'h00, 1'b0);
        run(12);
        check("t6_strobe", 32'(strobe_cnt),     32'd1);
        check("t6_index",  32'(last_idx),       32'd2);
        check("t6_hex",    32'(digit_hex),      32'h105F);
        check("t6_known",  32'(digit_known),    32'hB);
        check("t6_dp",     32'(digit_dp),       32'h0);
        check("t6_valid2", 32'(digit_valid[2]), 32'h1);

        // Reset during SETTLE clears everything at once
        set_bus(4'b1110, 7'h06, 1'b0);
        run(4);
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        set_bus(4'b1111, 7'h00, 1'b0);
        run(3);
        reset_n = 1'b1;
        clear_mon();
        run(20);
        check("t6_no_strobe", 32'(strobe_cnt), 32'd0);
        check_all_zero("t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
